// File: rtl/fixed_point_booth_multiplier.sv
// Sequential signed fixed-point multiplier, radix-4 Booth, one digit per clock.
// Q(WIDTH-FRAC_BITS).FRAC_BITS operands and result; optional round-half-up and
// saturate-or-wrap on overflow; start/finish handshake with a busy indication.
// WIDTH must be even and >= 4; 1 <= FRAC_BITS < WIDTH.
module fixed_point_booth_multiplier #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8,
  parameter bit SATURATE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  input  logic             round_en,
  output logic [WIDTH-1:0] result,
  output logic             overflow_flag,
  output logic             finish,
  output logic             busy
);

  // Accumulator is two bits wider than the product so the +/-2a partial
  // products of the top digit never wrap before the sum settles.
  localparam int ACC_W  = 2 * WIDTH + 2;
  localparam int DIGITS = WIDTH / 2;
  localparam int CNT_W  = $clog2(DIGITS + 1);

  // Representable range of the result, sign-extended to accumulator width.
  localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] HALF_LSB = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  state_e                    state_q,  state_d;
  logic signed [ACC_W-1:0]   acc_q,    acc_d;
  logic signed [ACC_W-1:0]   mcand_q,  mcand_d;   // a, pre-shifted to weight 4^k
  logic        [WIDTH:0]     mplier_q, mplier_d;  // {b, 0}: window sits in [2:0]
  logic        [CNT_W-1:0]   cnt_q,    cnt_d;
  logic                      round_q,  round_d;
  logic        [WIDTH-1:0]   result_q, result_d;
  logic                      ovf_q,    ovf_d;

  logic signed [ACC_W-1:0]   pp;
  logic signed [ACC_W-1:0]   rounded;
  logic signed [ACC_W-1:0]   scaled;
  logic                      fix_ovf;
  logic        [WIDTH-1:0]   fix_res;

  // Booth recode of the current 3-bit window of b into {0, +-a, +-2a}.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pp = '0;
    unique case (mplier_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q <<< 1;
      3'b100:         pp = -(mcand_q <<< 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end

  // Round, rescale and range-check the finished product held in the accumulator.
  always_comb begin
    rounded = acc_q + (round_q ? HALF_LSB : '0);
    scaled  = rounded >>> FRAC_BITS;
    fix_ovf = (scaled > S_MAX) || (scaled < S_MIN);
    fix_res = scaled[WIDTH-1:0];
    if (fix_ovf && SATURATE) begin
      fix_res = scaled[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Next-state and datapath update for the IDLE/RUN/FIX/DONE sequence.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    round_d  = round_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = {{(ACC_W-WIDTH){a[WIDTH-1]}}, a};
          mplier_d = {b, 1'b0};
          cnt_d    = '0;
          round_d  = round_en;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = acc_q + pp;
        mcand_d  = mcand_q <<< 2;
        mplier_d = {2'b00, mplier_q[WIDTH:2]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIGITS - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_res;
        ovf_d    = fix_ovf;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset overrides any start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      round_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      round_q  <= round_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result        = result_q;
  assign overflow_flag = ovf_q;
  assign finish        = (state_q == S_DONE);
  assign busy          = (state_q == S_RUN) || (state_q == S_FIX);

endmodule

// File: tb/tb_fixed_point_booth_multiplier.sv
// Directed and random checks of the Booth fixed-point multiplier in three
// configurations: 16/8 saturating, 16/8 wrapping, 8/4 saturating.
module tb_fixed_point_booth_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] a16, b16;
  logic        start16, rnd16;
  logic [15:0] res_s, res_w;
  logic        ovf_s, ovf_w, fin_s, fin_w, busy_s, busy_w;

  logic [7:0]  a8, b8;
  logic        start8, rnd8;
  logic [7:0]  res8;
  logic        ovf8, fin8, busy8;

  fixed_point_booth_multiplier #(.WIDTH(16), .FRAC_BITS(8), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .start(start16), .round_en(rnd16),
    .result(res_s), .overflow_flag(ovf_s), .finish(fin_s), .busy(busy_s));

  fixed_point_booth_multiplier #(.WIDTH(16), .FRAC_BITS(8), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .start(start16), .round_en(rnd16),
    .result(res_w), .overflow_flag(ovf_w), .finish(fin_w), .busy(busy_w));

  fixed_point_booth_multiplier #(.WIDTH(8), .FRAC_BITS(4), .SATURATE(1'b1)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .start(start8), .round_en(rnd8),
    .result(res8), .overflow_flag(ovf8), .finish(fin8), .busy(busy8));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: direct integer product, then round/shift/clamp. Returns {ovf, result}.
  function automatic logic [16:0] model(input int w, input int f, input logic [15:0] a,
                                        input logic [15:0] b, input logic rnd, input bit sat);
    longint one = 1;
    longint mask, sa, sb, p, s, mx, mn, r;
    logic   ovf;
    mask = (one << w) - 1;
    sa = longint'({48'b0, a}) & mask;
    sb = longint'({48'b0, b}) & mask;
    if (sa >= (one << (w - 1))) sa -= (one << w);
    if (sb >= (one << (w - 1))) sb -= (one << w);
    p = sa * sb;
    if (rnd) p += one << (f - 1);
    s  = p >>> f;
    mx = (one << (w - 1)) - 1;
    mn = -(one << (w - 1));
    ovf = (s > mx) || (s < mn);
    r = (ovf && sat) ? ((s > 0) ? mx : mn) : s;
    r = r & mask;
    return {ovf, r[15:0]};
  endfunction

  // Present operands and start for exactly one accepting edge.
  task automatic start_op16(input logic [15:0] a, input logic [15:0] b, input logic rnd);
    @(negedge clk);
    a16 = a; b16 = b; rnd16 = rnd; start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    a16 = 16'hDEAD; b16 = 16'hBEEF; rnd16 = ~rnd;
  endtask

  // Count edges until both 16-bit instances finish; busy must stay high meanwhile.
  task automatic wait_fin16(output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (fin_s && fin_w) begin
        lat = c;
        break;
      end
      busy_ok &= busy_s & busy_w;
    end
  endtask

  task automatic run16(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic rnd, input logic [15:0] exp_s, input logic [15:0] exp_w,
                       input logic exp_ovf);
    int lat;
    bit ok0, busy_ok;
    start_op16(a, b, rnd);
    ok0 = busy_s && busy_w && !fin_s && !fin_w;
    wait_fin16(lat, busy_ok);
    check({name, ".latency"}, lat, 9);
    check({name, ".busy"}, {31'b0, ok0 && busy_ok}, 1);
    check({name, ".busy_done"}, {30'b0, busy_s, busy_w}, 0);
    check({name, ".res_sat"}, {16'b0, res_s}, {16'b0, exp_s});
    check({name, ".res_wrap"}, {16'b0, res_w}, {16'b0, exp_w});
    check({name, ".ovf"}, {30'b0, ovf_s, ovf_w}, {30'b0, exp_ovf, exp_ovf});
  endtask

  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic rnd, input logic [7:0] exp_r, input logic exp_ovf);
    int lat;
    lat = -1;
    @(negedge clk);
    a8 = a; b8 = b; rnd8 = rnd; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (fin8) begin
        lat = c;
        break;
      end
    end
    check({name, ".latency"}, lat, 5);
    check({name, ".res"}, {24'b0, res8}, {24'b0, exp_r});
    check({name, ".ovf"}, {31'b0, ovf8}, {31'b0, exp_ovf});
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        rnd;
    logic [15:0] exp_sat;
    logic [15:0] exp_wrap;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int lat;
    bit busy_ok;
    logic [16:0] es, ew;
    logic [15:0] ra, rb;
    logic        rr;

    //            a         b         rnd   sat       wrap      ovf
    vecs[0]  = '{16'h0180, 16'h0200, 1'b0, 16'h0300, 16'h0300, 1'b0}; // 1.5*2.0
    vecs[1]  = '{16'hFF00, 16'h0280, 1'b0, 16'hFD80, 16'hFD80, 1'b0}; // -1.0*2.5
    vecs[2]  = '{16'h8000, 16'h8000, 1'b0, 16'h7FFF, 16'h0000, 1'b1}; // -128*-128
    vecs[3]  = '{16'h7F00, 16'h0200, 1'b0, 16'h7FFF, 16'hFE00, 1'b1}; // 127*2
    vecs[4]  = '{16'h0001, 16'h0080, 1'b0, 16'h0000, 16'h0000, 1'b0}; // tiny, floor
    vecs[5]  = '{16'h0001, 16'h0080, 1'b1, 16'h0001, 16'h0001, 1'b0}; // tiny, round up
    vecs[6]  = '{16'hFFFF, 16'h0080, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0}; // -tiny, floor
    vecs[7]  = '{16'hFFFF, 16'h0080, 1'b1, 16'h0000, 16'h0000, 1'b0}; // -tiny, round
    vecs[8]  = '{16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 16'hFF00, 1'b1}; // max*max
    vecs[9]  = '{16'h8000, 16'h0100, 1'b0, 16'h8000, 16'h8000, 1'b0}; // min*1, exact fit
    vecs[10] = '{16'h8000, 16'hFF00, 1'b0, 16'h7FFF, 16'h8000, 1'b1}; // min*-1
    vecs[11] = '{16'h0505, 16'h1980, 1'b0, 16'h7FFF, 16'h7FFF, 1'b0}; // 32767.5 floored
    vecs[12] = '{16'h0505, 16'h1980, 1'b1, 16'h7FFF, 16'h8000, 1'b1}; // rounding overflows
    vecs[13] = '{16'hFE80, 16'h0180, 1'b0, 16'hFDC0, 16'hFDC0, 1'b0}; // -1.5*1.5

    rst = 1'b1;
    start16 = 1'b0; rnd16 = 1'b0; a16 = '0; b16 = '0;
    start8 = 1'b0;  rnd8 = 1'b0;  a8 = '0;  b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.outs16", {res_s, ovf_s, fin_s, busy_s, 12'b0}, 32'h0);
    check("reset.outs16w", {res_w, ovf_w, fin_w, busy_w, 12'b0}, 32'h0);
    check("reset.outs8", {20'b0, res8, ovf8, fin8, busy8, 1'b0}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run16($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].rnd,
            vecs[i].exp_sat, vecs[i].exp_wrap, vecs[i].exp_ovf);
    end

    // start during RUN is ignored: first operands complete at cycle 9
    start_op16(16'h0180, 16'h0200, 1'b0);
    repeat (3) @(posedge clk);
    start_op16(16'h7F00, 16'h0200, 1'b1);
    wait_fin16(lat, busy_ok);
    check("ignored_start.latency", lat, 5);
    check("ignored_start.res", {16'b0, res_s}, 32'h0300);
    check("ignored_start.ovf", {31'b0, ovf_s}, 0);

    // start in DONE: finish drops at the accepting edge, new result 9 cycles later
    start_op16(16'hFF00, 16'h0280, 1'b0);
    check("restart.fin_drop", {30'b0, fin_s, busy_s}, 32'h1);
    wait_fin16(lat, busy_ok);
    check("restart.latency", lat, 9);
    check("restart.res", {16'b0, res_s}, 32'hFD80);

    // reset at cycle 4 of RUN clears everything, including the old result
    start_op16(16'h0100, 16'h0100, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset.outs", {res_s, ovf_s, fin_s, busy_s, 12'b0}, 32'h0);
    // reset wins over a simultaneous start
    @(negedge clk);
    start16 = 1'b1; a16 = 16'h0100; b16 = 16'h0100;
    @(posedge clk);
    #1;
    check("reset_vs_start", {30'b0, busy_s, fin_s}, 32'h0);
    @(negedge clk);
    start16 = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset.idle", {30'b0, busy_s, fin_s}, 32'h0);
    run16("fresh", 16'h0180, 16'h0200, 1'b0, 16'h0300, 16'h0300, 1'b0);

    // 8/4 directed: 1.5*2.0 = 3.0, overflow clamp, rounding
    run8("w8.basic", 8'h18, 8'h20, 1'b0, 8'h30, 1'b0);
    run8("w8.ovf", 8'h70, 8'h20, 1'b0, 8'h7F, 1'b1);
    run8("w8.round", 8'hFF, 8'h08, 1'b1, 8'h00, 1'b0);

    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rr = 1'($urandom);
      es = model(16, 8, ra, rb, rr, 1'b1);
      ew = model(16, 8, ra, rb, rr, 1'b0);
      run16($sformatf("rand16_%0d", i), ra, rb, rr, es[15:0], ew[15:0], es[16]);
    end

    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255)); rr = 1'($urandom);
      es = model(8, 4, ra, rb, rr, 1'b1);
      run8($sformatf("rand8_%0d", i), ra[7:0], rb[7:0], rr, es[7:0], es[16]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
